// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART blocks (uart_tx_cfg, uart_baud_tick).
package uart_pkg;

  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_DATA_BITS = 9;
  localparam int UART_MIN_DIV       = 2;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    TAIL,
    BREAK,
    MARK
  } tx_state_e;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] cfg, input int max_bits);
    if (int'(cfg) < UART_MIN_DATA_BITS) return 4'(UART_MIN_DATA_BITS);
    if (int'(cfg) > max_bits) return 4'(max_bits);
    return cfg;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period timer: counts 0..div-1 and flags the last cycle of each bit.
// Shared between the TX and a future RX so it keeps its own copy of the divisor.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 bit_end
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign bit_end = en && !load && !clear && (cnt_q == div_q - ONE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = div_in;
      cnt_d = '0;
    end else if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with ready/valid input and shadowed frame format.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic [3:0]            cfg_data_bits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  BREAK_REQ,
  output logic                  SERIAL_TX,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int MAX_BITS = (DATA_WIDTH > UART_MAX_DATA_BITS) ? UART_MAX_DATA_BITS : DATA_WIDTH;
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(UART_MIN_DIV);

  tx_state_e             state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            nbits_q, nbits_d;
  parity_e               parity_q, parity_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept, tick_load, tick_clear, tick_en, bit_end, break_req;
  logic [DIV_WIDTH-1:0]  div_clamped;
  logic [3:0]            cfg_bits_clamped;
  parity_e               cfg_parity_mode;
  logic [DATA_WIDTH-1:0] data_shift;

`ifdef UART_TX_BREAK_EN
  logic min_met_q, min_met_d;
  assign break_req = BREAK_REQ;
`else
  logic break_unused;
  assign break_req    = 1'b0;
  assign break_unused = BREAK_REQ;
`endif

  assign tick_en = (state_q != IDLE);

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk     (CLK),
    .rst_n   (RSTN),
    .load    (tick_load),
    .clear   (tick_clear),
    .en      (tick_en),
    .div_in  (div_clamped),
    .bit_end (bit_end)
  );

  always_comb begin
    cfg_bits_clamped = clamp_data_bits(cfg_data_bits, MAX_BITS);
    cfg_parity_mode  = (cfg_parity == 2'b11) ? NONE : parity_e'(cfg_parity);
    div_clamped      = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
  end

  // Unused high data bits are masked at accept so the parity bit covers only transmitted bits.
  always_comb begin
    data_d    = data_q;
    nbits_d   = nbits_q;
    parity_d  = parity_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    if (accept) begin
      data_d    = din & ~({DATA_WIDTH{1'b1}} << cfg_bits_clamped);
      nbits_d   = cfg_bits_clamped;
      parity_d  = cfg_parity_mode;
      stop2_d   = cfg_stop2;
      par_bit_d = (^data_d) ^ (cfg_parity_mode == ODD);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    accept     = 1'b0;
    tick_load  = 1'b0;
    tick_clear = 1'b0;
`ifdef UART_TX_BREAK_EN
    min_met_d  = min_met_q;
`endif
    case (state_q)
      IDLE: begin
        if (break_req) begin
          state_d   = BREAK;
          tick_load = 1'b1;
`ifdef UART_TX_BREAK_EN
          min_met_d = 1'b0;
`endif
        end else if (tx_valid) begin
          accept    = 1'b1;
          tick_load = 1'b1;
          idx_d     = '0;
          state_d   = START;
        end
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          if (idx_q == nbits_q - 4'd1) begin
            idx_d   = '0;
            state_d = (parity_q == NONE) ? STOP : PARITY;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (stop2_q && (idx_q == 4'd0)) idx_d = 4'd1;
          else state_d = TAIL;
        end
      end
      // SERIAL_TX lags the state by one register; TAIL covers the last stop cycle on the line.
      TAIL:   state_d = IDLE;
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (bit_end) min_met_d = 1'b1;
        if (!break_req && (min_met_q || bit_end)) begin
          state_d    = MARK;
          tick_clear = 1'b1;
        end
      end
      MARK:   if (bit_end) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_shift = data_q >> idx_q;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_shift[0];
      PARITY:  tx_d = par_bit_q;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_d = 1'b0;
`endif
      default: tx_d = 1'b1;
    endcase
    done_d  = (state_q == TAIL);
    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      nbits_q   <= '0;
      parity_q  <= NONE;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      min_met_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      nbits_q   <= nbits_d;
      parity_q  <= parity_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_BREAK_EN
      min_met_q <= min_met_d;
`endif
    end
  end

  assign SERIAL_TX = tx_q;
  assign tx_ready  = ready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. It succeeds the fixed-format UART TX in the peripherals/uart block.
- Adds a ready/valid input handshake with the data word and frame format latched at accept.
- Adds runtime baud divisor, data-bit count, parity mode and stop-bit count.
- Sits between the CPU-side UART register block (or a TX FIFO) and the SERIAL_TX pad.

Parameters:
DATA_WIDTH, 9, maximum data bits supported (legal range 5..9); sizes din.
DIV_WIDTH, 16, width of the baud divisor input.

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous active-low reset
baud_div  in  DIV_WIDTH  clocks per bit; values below 2 are treated as 2
cfg_data_bits  in  4  data bits per frame; below 5 treated as 5; above DATA_WIDTH treated as DATA_WIDTH
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
cfg_stop2  in  1  0: one stop bit, 1: two stop bits
din  in  DATA_WIDTH  data word, LSB transmitted first
tx_valid  in  1  word available
tx_ready  out  1  block can accept a word
BREAK_REQ  in  1  line-break request (used only with the optional feature)
SERIAL_TX  out  1  serial line, idle high
BUSY  out  1  frame or break in progress
DONE  out  1  one-cycle pulse at the end of a frame

Behaviour:
- Reset (asynchronous, active-low):
  - SERIAL_TX=1, DONE=0, BUSY=0, tx_ready=1, state=IDLE, all counters 0.
  - Reset mid-frame aborts the frame. SERIAL_TX returns high immediately and no DONE is issued.
- Accept:
  - A word is accepted when tx_valid && tx_ready on a CLK edge.
  - At that edge the block latches din, the clamped baud_div, cfg_data_bits, cfg_parity and cfg_stop2 into shadow registers.
  - Config changes during a frame have no effect until the next accept.
- tx_ready = (state==IDLE). BUSY = !tx_ready.
- States:
  - IDLE: SERIAL_TX=1. On accept go to START.
  - START: SERIAL_TX=0 for div cycles. Then go to DATA.
  - DATA: SERIAL_TX=shadow_data[idx], idx = 0..nbits-1, each bit for div cycles. After the last bit go to PARITY if parity is enabled, else STOP.
  - PARITY: even parity bit = XOR of the nbits transmitted bits; odd parity bit = its inverse. Held for div cycles. Then go to STOP.
  - STOP: SERIAL_TX=1 for div cycles, or 2*div cycles if stop2 is set. Then go to IDLE.
- Timing:
  - The frame occupies F = 1 + nbits + P + S bit periods. P is 0 or 1; S is 1 or 2.
  - Accept at edge t: SERIAL_TX goes low after edge t+1 and stays low for exactly div cycles.
  - The last stop bit ends at edge t+1+F*div. At that edge state=IDLE and DONE=1 for that one cycle.
- Back-to-back frames:
  - tx_valid held high is accepted in the DONE cycle.
  - The next start bit follows the previous stop bit with no extra idle bit (one idle cycle only).
- Bit timer:
  - Counter runs 0..div-1. Bit advance occurs on the cycle where count==div-1; the counter is then cleared.
  - The counter is DIV_WIDTH bits wide and never wraps within a bit.
- All outputs are registered. No combinational path from din or cfg_* to SERIAL_TX.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - In IDLE, BREAK_REQ=1 has priority over tx_valid. No accept occurs; go to BREAK.
  - BREAK: SERIAL_TX=0, tx_ready=0, for as long as BREAK_REQ stays high. Minimum duration is one div period even if the request drops earlier.
  - On deassert go to MARK: SERIAL_TX=1 for one div period. Then go to IDLE. No DONE pulse.
- Not defined: BREAK_REQ is ignored, and the BREAK and MARK states are not synthesised.

Decomposition:
- Package uart_pkg holds:
  - Typedef parity_e (NONE, EVEN, ODD).
  - State enum tx_state_e.
  - Constants UART_MIN_DATA_BITS=5, UART_MAX_DATA_BITS=9, UART_MIN_DIV=2.
- One sub-module, uart_baud_tick: loadable divisor counter emitting a bit_end pulse. It is reusable by a future uart_rx_cfg.

Test Plan:
1. div=4, 8N1, din=0x55, tx_valid one cycle → SERIAL_TX low 4 cycles, then bits 1,0,1,0,1,0,1,0 of 4 cycles each, high 4 cycles; DONE exactly 41 cycles after accept.
2. div=3, 7 data bits, even parity, din=0x03 → parity bit 0; odd parity gives 1; 2 stop bits give 6 high cycles before DONE.
3. tx_valid held with din=0xA5 then 0x3C → second start bit begins one cycle after the first frame's DONE; tx_ready low throughout both frames.
4. baud_div=0 and cfg_data_bits=12 with DATA_WIDTH=9 → bits last 2 cycles, 9 data bits sent; config changed mid-frame has no effect.
5. RSTN low during DATA bit 3 → SERIAL_TX=1 and tx_ready=1 immediately; no DONE; next frame transmits correctly.
6. UART_TX_BREAK_EN, div=5, BREAK_REQ high 2 cycles with tx_valid=1 → SERIAL_TX low 5 cycles, high 5 cycles, then the pending word is accepted.
